// File: rtl/blck_serializer.sv
// Streams one BLCK_SIZE-bit block out on a BUS_SIZE-bit valid/ready bus, MSB word first,
// masking bytes past the block length. Optional BLCK_SERIALIZER_ZEROIZE_EN scrubs the register.
module blck_serializer #(
  parameter int unsigned BUS_SIZE  = 32,
  parameter int unsigned BLCK_SIZE = 256,
  localparam int unsigned BUSdiv8  = BUS_SIZE / 8,
  localparam int unsigned BLCKdiv8 = BLCK_SIZE / 8,
  localparam int unsigned LENW     = $clog2(BLCKdiv8) + 1,
  localparam int unsigned BW       = $clog2(BUSdiv8) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BLCK_SIZE-1:0] blck_in,
  input  logic [LENW-1:0]      blck_in_len,
  input  logic                 blck_in_last,
  input  logic                 blck_in_valid,
  output logic                 blck_in_ready,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic [BW-1:0]        data_out_bytes,
  output logic                 data_out_eot,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e               state_q, state_d;
  logic [BLCK_SIZE-1:0] shreg_q, shreg_d;
  logic [LENW-1:0]      rem_q, rem_d;
  logic                 last_q, last_d;

  logic [LENW-1:0]      len_sat;
  logic [LENW-1:0]      word_bytes;
  logic                 rem_is_tail;
  logic [BUS_SIZE-1:0]  top_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    len_sat     = (blck_in_len > LENW'(BLCKdiv8)) ? LENW'(BLCKdiv8) : blck_in_len;
    rem_is_tail = (rem_q <= LENW'(BUSdiv8));
    word_bytes  = rem_is_tail ? rem_q : LENW'(BUSdiv8);
    top_word    = shreg_q[BLCK_SIZE-1 -: BUS_SIZE];
  end

  // Outputs are pure functions of registered state: no path from blck_in or data_out_ready.
  always_comb begin
    blck_in_ready  = (state_q == StIdle);
    data_out_valid = (state_q == StSend);
    data_out_bytes = data_out_valid ? BW'(word_bytes) : '0;
    data_out_eot   = data_out_valid & last_q & rem_is_tail;
    data_out       = '0;
    for (int unsigned i = 0; i < BUSdiv8; i++) begin
      if (BW'(i) < data_out_bytes) begin
        data_out[BUS_SIZE-1-8*i -: 8] = top_word[BUS_SIZE-1-8*i -: 8];
      end
    end
`ifdef BLCK_SERIALIZER_ZEROIZE_EN
    if (!data_out_valid) begin
      data_out = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (blck_in_valid) begin
          shreg_d = blck_in;
          rem_d   = len_sat;
          last_d  = blck_in_last;
          if (len_sat != '0) begin
            state_d = StSend;
          end else begin
`ifdef BLCK_SERIALIZER_ZEROIZE_EN
            shreg_d = '0;
            last_d  = 1'b0;
`endif
          end
        end
      end
      StSend: begin
        if (data_out_ready) begin
          shreg_d = shreg_q << BUS_SIZE;
          rem_d   = rem_q - word_bytes;
          if (rem_is_tail) begin
            state_d = StIdle;
`ifdef BLCK_SERIALIZER_ZEROIZE_EN
            shreg_d = '0;
            last_d  = 1'b0;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/blck_serializer.md
# blck_serializer

Downstream companion of the block builder: accepts one processed BLCK_SIZE-bit block (permutation output, ciphertext or tag block) with a byte length and streams it out on the BUS_SIZE-bit data bus, MSB word first. It handles the truncated last block of a message, masks unused bytes, flags end-of-text and honours output backpressure with a valid/ready handshake. It sits between the mode datapath's block register and the output FIFO.

## Interface
- BUS_SIZE, 32: output bus width in bits; one of 8, 16, 32.
- BLCK_SIZE, 256: block width in bits; a multiple of BUS_SIZE.
- Derived: BUSdiv8 = BUS_SIZE/8; BLCKdiv8 = BLCK_SIZE/8; LENW = $clog2(BLCKdiv8)+1; BW = $clog2(BUSdiv8)+1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- blck_in  in  BLCK_SIZE  block to emit; byte 0 = bits [BLCK_SIZE-1 -: 8].
- blck_in_len  in  LENW  number of valid bytes, 0..BLCKdiv8; larger values saturate to BLCKdiv8.
- blck_in_last  in  1  block is the last of the message; drives eot on its final word.
- blck_in_valid  in  1  block, len and last are valid.
- blck_in_ready  out  1  high only in IDLE; block taken when valid & ready at a rising edge.
- data_out  out  BUS_SIZE  output word; lowest-index byte in the MSBs.
- data_out_bytes  out  BW  valid bytes in data_out, 1..BUSdiv8, MSB-aligned.
- data_out_eot  out  1  word is the final word of a last block.
- data_out_valid  out  1  word is presented.
- data_out_ready  in  1  consumer accepts the word at this rising edge.

## Operation
- States: IDLE, SEND. Reset -> IDLE.
- IDLE: blck_in_ready=1. On blck_in_valid: load shift register with blck_in, remaining-byte counter rem with min(blck_in_len, BLCKdiv8), latch last. rem=0 -> stay IDLE, nothing emitted, block discarded. rem>0 -> SEND.
- SEND: data_out_valid=1; data_out = top BUS_SIZE bits of shift register with bytes at index >= data_out_bytes forced to zero; data_out_bytes = min(rem, BUSdiv8); data_out_eot = last & (rem <= BUSdiv8).
- On transfer (valid & ready): shift register shifts left by BUS_SIZE (zero fill); rem -= data_out_bytes. If rem <= BUSdiv8 before transfer -> IDLE.
- Without transfer: all outputs held stable, no state change.
- rem is LENW bits wide and never underflows; saturation applied on load only.
- Reset mid-block: block aborted, no further words, no eot emitted.

## Timing
- Reset values: blck_in_ready=1, data_out_valid=0, data_out=0, data_out_bytes=0, data_out_eot=0.
- Block accepted at edge t -> first word valid in cycle t+1 (registered, no combinational path from blck_in to data_out).
- Full block with data_out_ready tied high: BLCK_SIZE/BUS_SIZE consecutive cycles of valid words, then one IDLE cycle; throughput N words per N+1 cycles.
- blck_in_ready rises in the cycle after the final transfer; never combinationally dependent on data_out_ready.
- data_out_ready may toggle arbitrarily; valid never drops before a transfer.

## Configuration
- BLCK_SERIALIZER_ZEROIZE_EN defined: shift register and latched last cleared to zero on the edge of the final transfer and on the rem=0 discard; data_out forced to zero whenever data_out_valid=0. No residual block material remains in the register after emission.
- Not defined: shift register keeps the shifted residue until the next load; data_out in IDLE reflects the register contents masked by data_out_bytes=0 (i.e. zero bytes valid, raw value unspecified). Handshake and valid-word content identical in both builds.

## Test plan
- BUS_SIZE=32, BLCK_SIZE=256, len=32, last=1, ready=1 -> 8 words on cycles t+1..t+8, bytes=4 each, eot only on the 8th, blck_in_ready=1 in cycle t+9.
- len=5, last=1, blck_in=0x0102030405FF..FF -> word 0x01020304 bytes=4 eot=0, then 0x05000000 bytes=1 eot=1.
- len=32, ready low for 4 cycles while word 3 presented -> word 3 and bytes stable throughout, no word lost or duplicated, 8 transfers total.
- len=0 then len=40 -> first block emits nothing, ready back next cycle; second saturates to 32 bytes, 8 words.
- rst asserted after 3 of 8 transfers -> all outputs at reset values immediately, next block streams from its word 0.
- ZEROIZE build, len=4 -> after the single transfer, data_out=0 and internal register reads zero in the following cycle.
